// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one pipeline request per handshake, issued on the
// byte-addressed data-memory port, with halfwords split into two big-endian byte accesses.
module mem_access_unit #(
    parameter int ADDR_BITS   = 10,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [1:0]  Mem_Write_Read,
    output logic        word_byte,
    input  logic [31:0] Read_data
);

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state;
    logic        lat_write;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [4:0]  lat_rd;
    logic [7:0]  lat_wdata_lo;
    logic [7:0]  hi_byte;

    logic        accept;
    logic        range_bad;
    logic        align_bad;
    logic        req_fault;
    logic [31:0] addr_eff;
    logic [31:0] cmd_data;

    assign accept = req_valid & req_ready;

    // Fault classification and the memory-side address/data for the first access.
    always_comb begin
        addr_eff  = req_addr & ADDR_MASK;
        range_bad = (req_addr & ~ADDR_MASK) != 32'h0;
        align_bad = 1'b0;
        if (CHECK_ALIGN) begin
            align_bad = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        end else if (req_size == SZ_HALF) begin
            addr_eff[0] = 1'b0;
        end else if (req_size == SZ_WORD) begin
            addr_eff[1:0] = 2'b00;
        end
        req_fault = (req_size == SZ_ILL) || range_bad || align_bad;

        case (req_size)
            SZ_WORD: cmd_data = req_wdata;
            SZ_HALF: cmd_data = {24'h0, req_wdata[15:8]};
            default: cmd_data = {24'h0, req_wdata[7:0]};
        endcase
    end

    function automatic logic [31:0] extend(input logic [31:0] data,
                                           input logic [1:0]  size,
                                           input logic        sgn);
        case (size)
            SZ_BYTE: extend = {{24{sgn & data[7]}}, data[7:0]};
            SZ_HALF: extend = {{16{sgn & data[15]}}, data[15:0]};
            default: extend = data;
        endcase
    endfunction

    // NOTE: every register in this block uses <= so all of them sample the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_rd        <= 5'h0;
            Mem_Write_Read <= CMD_IDLE;
            address        <= 32'h0;
            write_data     <= 32'h0;
            word_byte      <= 1'b0;
            lat_write      <= 1'b0;
            lat_signed     <= 1'b0;
            lat_size       <= SZ_BYTE;
            lat_rd         <= 5'h0;
            lat_wdata_lo   <= 8'h0;
            hi_byte        <= 8'h0;
        end else begin
            // NOTE: defaults here make resp_valid and the memory command one-cycle pulses
            // unless a branch below re-asserts them.
            resp_valid     <= 1'b0;
            Mem_Write_Read <= CMD_IDLE;

            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        lat_write    <= req_write;
                        lat_signed   <= req_signed;
                        lat_size     <= req_size;
                        lat_rd       <= req_rd;
                        lat_wdata_lo <= req_wdata[7:0];
                        if (req_fault) begin
                            state      <= RESP;
                            req_ready  <= 1'b1;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_rd    <= req_rd;
                        end else begin
                            state          <= ACC0;
                            req_ready      <= 1'b0;
                            Mem_Write_Read <= req_write ? CMD_WRITE : CMD_READ;
                            address        <= addr_eff;
                            write_data     <= cmd_data;
                            word_byte      <= (req_size != SZ_WORD);
                        end
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end

                ACC0: begin
                    if (lat_size == SZ_HALF) begin
                        // Big-endian: the byte at the even address is the high half.
                        hi_byte        <= Read_data[7:0];
                        state          <= ACC1;
                        Mem_Write_Read <= lat_write ? CMD_WRITE : CMD_READ;
                        address        <= {address[31:1], 1'b1};
                        write_data     <= {24'h0, lat_wdata_lo};
                        word_byte      <= 1'b1;
                    end else begin
                        state      <= RESP;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rd    <= lat_rd;
                        resp_rdata <= lat_write ? 32'h0 : extend(Read_data, lat_size, lat_signed);
                    end
                end

                ACC1: begin
                    state      <= RESP;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rd    <= lat_rd;
                    resp_rdata <= lat_write ? 32'h0 :
                                  extend({16'h0, hi_byte, Read_data[7:0]}, lat_size, lat_signed);
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// against a byte-array reference model of the data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  Mem_Write_Read;
    logic        word_byte;
    logic [31:0] Read_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_err(resp_err),
        .address(address), .write_data(write_data), .Mem_Write_Read(Mem_Write_Read),
        .word_byte(word_byte), .Read_data(Read_data)
    );

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [4:0]  rd;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int unsigned at;
    } resp_t;

    typedef struct {
        logic [1:0]  mwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wb;
    } cmd_t;

    // Data memory environment: big-endian words, byte[4k+3] = 4k+4 preload.
    logic [7:0] mem [0:1023];
    logic       preloaded = 1'b0;

    always_comb begin
        Read_data = 32'h0;
        if (Mem_Write_Read == 2'b10) begin
            if (word_byte) Read_data = {24'h0, mem[address[9:0]]};
            else Read_data = {mem[address[9:0]], mem[address[9:0] + 10'd1],
                              mem[address[9:0] + 10'd2], mem[address[9:0] + 10'd3]};
        end
    end

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i % 4 == 3) ? 8'(i + 1) : 8'h00;
            preloaded <= 1'b1;
        end else if (Mem_Write_Read == 2'b01) begin
            if (word_byte) begin
                mem[address[9:0]] <= write_data[7:0];
            end else begin
                mem[address[9:0]]         <= write_data[31:24];
                mem[address[9:0] + 10'd1] <= write_data[23:16];
                mem[address[9:0] + 10'd2] <= write_data[15:8];
                mem[address[9:0] + 10'd3] <= write_data[7:0];
            end
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    resp_t got_q[$];
    cmd_t  gcmd_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) got_q.push_back('{resp_rd, resp_rdata, resp_err, cyc});
            if (Mem_Write_Read != 2'b00)
                gcmd_q.push_back('{Mem_Write_Read, address, write_data, word_byte});
        end
    end

    logic [7:0]  ref_mem [0:1023];
    resp_t       exp_q[$];
    cmd_t        ecmd_q[$];
    int unsigned acc_q[$];
    int          got_base = 0;
    int          cmd_base = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s: bound expired without the expected DUT event", tag);
    endtask

    function automatic req_t mk(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_t r;
        r = '{w, sz, sg, a, wd, rd};
        return r;
    endfunction

    // Reference: what an access means in terms of memory bytes, independent of timing.
    task automatic model(input req_t r);
        resp_t       e;
        int          n;
        logic [63:0] v;
        logic [1:0]  mwr;
        n     = (r.sz == 2'b00) ? 1 : (r.sz == 2'b01) ? 2 : 4;
        mwr   = r.w ? 2'b01 : 2'b10;
        e.rd  = r.rd;
        e.rdata = 32'h0;
        e.err = (r.sz == 2'b11) || (r.a >= 32'd1024) || ((r.a & 32'(n - 1)) != 32'h0);
        e.at  = e.err ? 1 : (n == 2 ? 3 : 2);
        if (!e.err) begin
            if (r.w) begin
                for (int i = 0; i < n; i++)
                    ref_mem[r.a[9:0] + 10'(i)] = 8'(r.wd >> (8 * (n - 1 - i)));
            end else begin
                v = 64'h0;
                for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[r.a[9:0] + 10'(i)]);
                if (r.sg && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                e.rdata = v[31:0];
            end
            if (n == 2) begin
                for (int i = 0; i < 2; i++)
                    ecmd_q.push_back('{mwr, r.a + 32'(i), {24'h0, 8'(r.wd >> (8 * (1 - i)))}, 1'b1});
            end else begin
                ecmd_q.push_back('{mwr, r.a, (n == 4) ? r.wd : {24'h0, r.wd[7:0]}, (n == 1)});
            end
        end
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input req_t r);
        int budget = 0;
        req_valid  = 1'b1;
        req_write  = r.w;
        req_size   = r.sz;
        req_signed = r.sg;
        req_addr   = r.a;
        req_wdata  = r.wd;
        req_rd     = r.rd;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc_q.push_back(cyc);
        model(r);
    endtask

    task automatic drain();
        int    budget = 0;
        resp_t g;
        resp_t e;
        cmd_t  gc;
        cmd_t  ec;
        req_valid = 1'b0;
        while ((got_q.size() - got_base) < exp_q.size() && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) fail("resp_timeout");
        repeat (3) @(negedge clk);
        check("resp_count", 32'(got_q.size() - got_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (got_base + i) < got_q.size(); i++) begin
            g = got_q[got_base + i];
            e = exp_q[i];
            check("resp_rd", 32'(g.rd), 32'(e.rd));
            check("resp_rdata", g.rdata, e.rdata);
            check("resp_err", 32'(g.err), 32'(e.err));
            check("latency", 32'(g.at - acc_q[i] + 1), 32'(e.at));
        end
        check("cmd_count", 32'(gcmd_q.size() - cmd_base), 32'(ecmd_q.size()));
        for (int i = 0; i < ecmd_q.size() && (cmd_base + i) < gcmd_q.size(); i++) begin
            gc = gcmd_q[cmd_base + i];
            ec = ecmd_q[i];
            check("cmd_kind", 32'(gc.mwr), 32'(ec.mwr));
            check("cmd_addr", gc.addr, ec.addr);
            check("cmd_word_byte", 32'(gc.wb), 32'(ec.wb));
            if (ec.mwr == 2'b01) check("cmd_wdata", gc.wdata, ec.wdata);
        end
        if (got_q.size() > got_base) last_rdata = got_q[got_q.size() - 1].rdata;
        got_base = got_q.size();
        cmd_base = gcmd_q.size();
        exp_q.delete();
        ecmd_q.delete();
        acc_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        req_t r;
        int   n;
        int   k;

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = (i % 4 == 3) ? 8'(i + 1) : 8'h00;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_rd", 32'(resp_rd), 32'h0);
        check("rst_mem_cmd", 32'(Mem_Write_Read), 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        check("rst_word_byte", 32'(word_byte), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd3)); drain();
        check("word_load_0", last_rdata, 32'h0000_0004);

        issue(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd1)); drain();
        check("store_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEAD_BEEF);
        issue(mk(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 5'd2)); drain();
        check("lb_signed", last_rdata, 32'hFFFF_FFDE);
        issue(mk(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 5'd4)); drain();
        check("lb_unsigned", last_rdata, 32'h0000_00DE);

        issue(mk(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_8001, 5'd5)); drain();
        check("sh_bytes", {16'h0, mem[32], mem[33]}, 32'h0000_8001);
        issue(mk(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 5'd6)); drain();
        check("lh_signed", last_rdata, 32'hFFFF_8001);

        // Faulting requests back to back: each accepted the cycle after the previous.
        issue(mk(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 5'd9));
        issue(mk(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 5'd10));
        issue(mk(1'b1, 2'b11, 1'b0, 32'h0, 32'h1234_5678, 5'd11));
        issue(mk(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd12));
        drain();

        issue(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd13));
        issue(mk(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd14));
        issue(mk(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5'd15));
        issue(mk(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 5'd16));
        for (int i = 1; i < acc_q.size(); i++)
            check("b2b_spacing", 32'(acc_q[i] - acc_q[i - 1]), 32'd2);
        drain();
        check("b2b_last", last_rdata, 32'h0000_0010);

        // Reset while a word store sits in ACC0.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h30; req_wdata = 32'hC0FF_EE00; req_rd = 5'd7;
        @(posedge clk);
        @(negedge clk);
        check("rst_acc0_cmd", 32'(Mem_Write_Read), 32'h1);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_mem_cmd", 32'(Mem_Write_Read), 32'h0);
        check("midrst_resp_valid", 32'(resp_valid), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_resp", 32'(got_q.size() - got_base), 32'h0);
        // The memory saw the store command for a full cycle before the reset edge.
        ref_mem[10'h30] = 8'hC0; ref_mem[10'h31] = 8'hFF;
        ref_mem[10'h32] = 8'hEE; ref_mem[10'h33] = 8'h00;
        got_base = got_q.size();
        cmd_base = gcmd_q.size();
        issue(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd8)); drain();
        check("post_rst_load", last_rdata, 32'h0000_0004);

        for (int j = 0; j < 60; j++) begin
            r.w  = 1'($urandom_range(0, 1));
            r.sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r.sg = 1'($urandom_range(0, 1));
            n    = (r.sz == 2'b00) ? 1 : (r.sz == 2'b01) ? 2 : 4;
            k    = int'($urandom_range(0, 9));
            if (k == 0)      r.a = $urandom | 32'h0000_0400;
            else if (k == 1) r.a = 32'($urandom_range(0, 1023));
            else             r.a = 32'($urandom_range(0, 1023)) & ~32'(n - 1);
            r.wd = $urandom;
            r.rd = 5'($urandom_range(0, 31));
            issue(r);
            if (j % 3 == 2) drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store initiator for the pipelined processor: accepts one load/store request per handshake from the pipeline and issues it on the byte-addressed data-memory command interface.
- Returns load data with sign or zero extension, or a store acknowledge, plus a fault flag.
- Halfword accesses, which the data memory cannot do natively, are split into two sequential byte transactions.
- req_ready low is the pipeline stall source while an access is in flight.

Parameters:
- ADDR_BITS, 10, implemented memory address width in bytes (1 KiB); any address bit at or above ADDR_BITS set is a range fault.
- CHECK_ALIGN, 1, when 1, misaligned halfword/word requests fault; when 0, the address is forced down to natural alignment instead.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept; a request transfers on a rising edge with req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  destination register tag, returned unchanged.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_rd  out  5  tag of the completing request.
- resp_err  out  1  fault: illegal size, misalignment, or range.
- address  out  32  memory byte address.
- write_data  out  32  memory store data.
- Mem_Write_Read  out  2  10 read, 01 write, 00 idle.
- word_byte  out  1  0 word, 1 byte.
- Read_data  in  32  memory read data, valid from the falling edge of a cycle driving 10.

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0, resp_rd=0; Mem_Write_Read=00, address=0, write_data=0, word_byte=0. All memory-side outputs are registered.
- FSM states: IDLE, ACC0, ACC1, RESP.
- req_ready=1 in IDLE and RESP, 0 in ACC0/ACC1.
- Accept, legal request: the request is latched and the unit enters ACC0.
- Accept, faulting request: the unit goes directly to RESP with resp_err=1 and resp_rdata=0. No memory command is ever issued for a faulting request.
- ACC0, byte or word: drive the command (word_byte = size==byte; Mem_Write_Read 10 or 01). Store data is req_wdata for a word, req_wdata[7:0] zero-extended for a byte. On the next edge, a load captures Read_data; the state moves to RESP.
- ACC0, halfword: byte access at addr with data req_wdata[15:8]; capture Read_data[7:0] as the high byte; move to ACC1.
- ACC1, halfword: byte access at addr+1 with data req_wdata[7:0]; capture the low byte; move to RESP.
- Halfword ordering is big-endian, matching the memory's word byte order.
- Mem_Write_Read returns to 00 in every cycle outside ACC0/ACC1.
- RESP: resp_valid=1 for exactly one cycle; resp_rd = latched tag.
- Load result extension: byte extends from bit 7, halfword from bit 15, word passes unchanged.
- A request accepted in RESP goes to ACC0 (or back to RESP on a fault); otherwise RESP returns to IDLE.
- Latency, accept edge to resp_valid: byte/word 2 cycles; halfword 3 cycles; fault 1 cycle.
- Back-to-back throughput: one word/byte access every 2 cycles.
- Inputs are ignored while req_ready=0; the latched request is stable for the whole access.
- Address out is req_addr with bits at or above ADDR_BITS cleared; address+1 for a halfword cannot carry past an aligned halfword.
- CHECK_ALIGN=0: halfword forces addr[0]=0, word forces addr[1:0]=0; no alignment fault is raised.
- Reset mid-operation: the next edge forces IDLE and Mem_Write_Read=00; no response is generated. A halfword store interrupted after ACC0 leaves its first byte written; this is accepted behaviour.

Test Plan:
- Setup: memory model preloaded with byte[4k+3]=4k+4 and all other bytes 0.
- Word load at 0x0, tag 3 -> Mem_Write_Read=10 and word_byte=0 for one cycle; resp_valid 2 cycles after accept; resp_rdata=0x00000004, resp_rd=3, resp_err=0.
- Word store 0xDEADBEEF to 0x10, then signed byte load at 0x10 -> memory bytes 0x10..0x13 = DE AD BE EF; load returns 0xFFFFFFDE. Same load unsigned returns 0x000000DE.
- Halfword store 0x8001 to 0x20, then signed halfword load at 0x20 -> two byte writes, 0x80 at 0x20 then 0x01 at 0x21; load returns 0xFFFF8001 at 3-cycle latency.
- Faults (CHECK_ALIGN=1): word load at 0x6, halfword at 0x21, size 11, address 0x400 -> each gives resp_err=1 and resp_rdata=0 one cycle after accept; Mem_Write_Read stays 00 throughout.
- Back-to-back: req_valid held with 4 word loads at 0x0/0x4/0x8/0xC -> accepts every 2 cycles; results 4, 8, 12, 16 in order with matching tags.
- Reset: rst_n low during ACC0 of a word store to 0x30 -> next cycle IDLE with Mem_Write_Read=00 and no resp_valid; after release, a word load at 0x0 completes normally with 0x00000004.
